// File: rtl/store_buffer_if.sv
// Bus bundle between the MEM stage / data memory and the store buffer.
// master = pipeline plus memory environment, slave = the buffer itself.
interface store_buffer_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_rdata;
    logic          fence_req;
    logic          fence_done;
    logic          mem_dwe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, fence_req, mem_rdata,
        input  st_ready, ld_rdata, fence_done, mem_dwe, mem_addr, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, fence_req, mem_rdata,
        output st_ready, ld_rdata, fence_done, mem_dwe, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues stores, drains when the memory port is free, forwards to loads.
// Define STORE_BUF_COALESCE_EN to merge a store into a pending entry with the same address.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave bus
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    logic             full;
    logic             drain;
    logic             push;
    logic             coal_hit;
    logic [DEPTH-1:0] coal_match;
    logic [PW-1:0]    scan_idx;
    logic [DW-1:0]    fwd_data;
    logic             fwd_hit;

    assign full  = (count == FULL_CNT);
    assign drain = !bus.ld_valid && (count != '0);

`ifdef STORE_BUF_COALESCE_EN
    // The head entry leaving this cycle cannot absorb a store; it must allocate instead.
    always_comb begin
        coal_match = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            coal_match[i] = ent_valid[i] && (ent_addr[i] == bus.st_addr) &&
                            !(drain && (head == PW'(i)));
        end
    end
`else
    assign coal_match = '0;
`endif

    assign coal_hit     = |coal_match;
    assign bus.st_ready = !full || coal_hit;
    assign push         = bus.st_valid && bus.st_ready && !coal_hit;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = head;
        for (int k = 0; k < int'(DEPTH); k++) begin
            scan_idx = head + PW'(k);
            if (ent_valid[scan_idx] && (ent_addr[scan_idx] == bus.ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[scan_idx];
            end
        end
    end

    assign bus.ld_rdata   = fwd_hit ? fwd_data : bus.mem_rdata;
    assign bus.fence_done = (count == '0);

    always_comb begin
        bus.mem_dwe   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.ld_valid) begin
            bus.mem_addr = bus.ld_addr;
        end else if (drain) begin
            bus.mem_dwe   = 1'b1;
            bus.mem_addr  = ent_addr[head];
            bus.mem_wdata = ent_data[head];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (drain) begin
                head            <= head + PW'(1);
                ent_valid[head] <= 1'b0;
            end
            if (push) begin
                tail            <= tail + PW'(1);
                ent_valid[tail] <= 1'b1;
            end
            if (push && !drain) begin
                count <= count + (PW + 1)'(1);
            end else if (!push && drain) begin
                count <= count - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= bus.st_addr;
            ent_data[tail] <= bus.st_data;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (bus.st_valid && coal_match[i]) begin
                ent_data[i] <= bus.st_data;
            end
        end
    end
endmodule
